// File: rtl/keyboard_cmd_fsm_pkg.sv
// rtl/keyboard_cmd_fsm_pkg.sv - key codes, state encodings and command type for the keyboard decoder
package kbd_cmd_pkg;

    localparam logic [7:0] KEY_PLAY    = 8'h45;
    localparam logic [7:0] KEY_STOP    = 8'h44;
    localparam logic [7:0] KEY_FWD     = 8'h46;
    localparam logic [7:0] KEY_BWD     = 8'h42;
    localparam logic [7:0] KEY_RESTART = 8'h52;
    localparam logic [7:0] KEY_UP      = 8'h55;
    localparam logic [7:0] KEY_DOWN    = 8'h4C;
    localparam logic [7:0] KEY_SPD_RST = 8'h54;

    localparam logic [7:0] KEY_LC_A  = 8'h61;
    localparam logic [7:0] KEY_LC_Z  = 8'h7A;
    localparam logic [7:0] CASE_MASK = 8'h20;

    // bit0 = direction (1 forward), bit1 = playing
    localparam logic [3:0] ST_STOP_BWD = 4'b0000;
    localparam logic [3:0] ST_STOP_FWD = 4'b0001;
    localparam logic [3:0] ST_PLAY_BWD = 4'b0010;
    localparam logic [3:0] ST_PLAY_FWD = 4'b0011;
    localparam int ST_DIR_BIT  = 0;
    localparam int ST_PLAY_BIT = 1;

    typedef logic [3:0] kbd_state_t;

    typedef struct packed {
        logic play;
        logic stop;
        logic fwd;
        logic bwd;
        logic rst;
        logic up;
        logic down;
        logic spd_rst;
    } kbd_cmd_t;

endpackage

// File: rtl/keyboard_cmd_fsm_if.sv
// rtl/keyboard_cmd_fsm_if.sv - key strobe input and player control outputs of the keyboard decoder
interface keyboard_cmd_fsm_if #(
    parameter int DIV_W = 16
);
    logic [7:0]       key_data;
    logic             key_valid;
    logic             forward_backward;
    logic             play_stop;
    logic             restart;
    logic [DIV_W-1:0] speed_div;
    logic [3:0]       state;

    modport master (
        output key_data, key_valid,
        input  forward_backward, play_stop, restart, speed_div, state
    );

    modport slave (
        input  key_data, key_valid,
        output forward_backward, play_stop, restart, speed_div, state
    );
endinterface

// File: rtl/keyboard_cmd_fsm_key_decode.sv
// rtl/keyboard_cmd_fsm_key_decode.sv - combinational ASCII to one-hot command decode with optional case fold
module kbd_key_decode
    import kbd_cmd_pkg::*;
#(
    parameter bit CASE_FOLD = 1'b1
) (
    input  logic [7:0] i_key_data,
    input  logic       i_key_valid,
    output kbd_cmd_t   o_cmd
);
    logic [7:0] w_key;

    always_comb begin
        w_key = i_key_data;
        if (CASE_FOLD && (i_key_data >= KEY_LC_A) && (i_key_data <= KEY_LC_Z))
            w_key = i_key_data & ~CASE_MASK;

        o_cmd = '0;
        if (i_key_valid) begin
            case (w_key)
                KEY_PLAY:    o_cmd.play    = 1'b1;
                KEY_STOP:    o_cmd.stop    = 1'b1;
                KEY_FWD:     o_cmd.fwd     = 1'b1;
                KEY_BWD:     o_cmd.bwd     = 1'b1;
                KEY_RESTART: o_cmd.rst     = 1'b1;
                KEY_UP:      o_cmd.up      = 1'b1;
                KEY_DOWN:    o_cmd.down    = 1'b1;
                KEY_SPD_RST: o_cmd.spd_rst = 1'b1;
                default:     o_cmd         = '0;
            endcase
        end
    end
endmodule

// File: rtl/keyboard_cmd_fsm.sv
// rtl/keyboard_cmd_fsm.sv - keyboard command FSM: play/direction state, restart pulse, speed divisor
module keyboard_cmd_fsm
    import kbd_cmd_pkg::*;
#(
    parameter int               DIV_W       = 16,
    parameter logic [DIV_W-1:0] DIV_DEFAULT = 16'd1136,
    parameter logic [DIV_W-1:0] DIV_MIN     = 16'd256,
    parameter logic [DIV_W-1:0] DIV_MAX     = 16'd4544,
    parameter logic [DIV_W-1:0] DIV_STEP    = 16'd64,
    parameter int               RESTART_CYC = 4,
    parameter bit               CASE_FOLD   = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    keyboard_cmd_fsm_if.slave         kbd_if
);
    localparam int CNT_W = $clog2(RESTART_CYC + 1);

    if (!((DIV_MIN <= DIV_DEFAULT) && (DIV_DEFAULT <= DIV_MAX) && (RESTART_CYC >= 1))) begin : g_param_check
        $error("keyboard_cmd_fsm: need DIV_MIN<=DIV_DEFAULT<=DIV_MAX and RESTART_CYC>=1");
    end

    kbd_cmd_t         w_cmd;
    kbd_state_t       r_state;
    kbd_state_t       w_next_state;
    logic [CNT_W-1:0] r_rst_cnt;
    logic [DIV_W-1:0] r_speed_div;
    logic [DIV_W-1:0] w_next_speed;
    logic [DIV_W:0]   w_dec;
    logic [DIV_W:0]   w_inc;

    kbd_key_decode #(
        .CASE_FOLD (CASE_FOLD)
    ) u_decode (
        .i_key_data  (kbd_if.key_data),
        .i_key_valid (kbd_if.key_valid),
        .o_cmd       (w_cmd)
    );

    always_comb begin
        w_next_state = r_state;
        if (w_cmd.play) w_next_state[ST_PLAY_BIT] = 1'b1;
        if (w_cmd.stop) w_next_state[ST_PLAY_BIT] = 1'b0;
        if (w_cmd.fwd)  w_next_state[ST_DIR_BIT]  = 1'b1;
        if (w_cmd.bwd)  w_next_state[ST_DIR_BIT]  = 1'b0;
    end

    // One extra bit exposes the borrow/carry so saturation never sees a wrapped value
    assign w_dec = {1'b0, r_speed_div} - {1'b0, DIV_STEP};
    assign w_inc = {1'b0, r_speed_div} + {1'b0, DIV_STEP};

    always_comb begin
        w_next_speed = r_speed_div;
        if (w_cmd.up)
            w_next_speed = (w_dec[DIV_W] || (w_dec < {1'b0, DIV_MIN})) ? DIV_MIN : w_dec[DIV_W-1:0];
        else if (w_cmd.down)
            w_next_speed = (w_inc > {1'b0, DIV_MAX}) ? DIV_MAX : w_inc[DIV_W-1:0];
        else if (w_cmd.spd_rst)
            w_next_speed = DIV_DEFAULT;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_STOP_FWD;
            r_rst_cnt   <= '0;
            r_speed_div <= DIV_DEFAULT;
        end else begin
            r_state     <= w_next_state;
            r_speed_div <= w_next_speed;
            if (w_cmd.rst)
                r_rst_cnt <= CNT_W'(RESTART_CYC);
            else if (r_rst_cnt != '0)
                r_rst_cnt <= r_rst_cnt - CNT_W'(1);
        end
    end

    assign kbd_if.state            = r_state;
    assign kbd_if.forward_backward = r_state[ST_DIR_BIT];
    assign kbd_if.play_stop        = r_state[ST_PLAY_BIT];
    assign kbd_if.restart          = (r_rst_cnt != '0);
    assign kbd_if.speed_div        = r_speed_div;
endmodule

// File: tb/tb_keyboard_cmd_fsm.sv
// tb/tb_keyboard_cmd_fsm.sv - self-checking bench for keyboard_cmd_fsm with and without case folding
module tb_keyboard_cmd_fsm;
    import kbd_cmd_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    keyboard_cmd_fsm_if #(.DIV_W(16)) if_f1 ();
    keyboard_cmd_fsm_if #(.DIV_W(16)) if_f0 ();

    keyboard_cmd_fsm #(.CASE_FOLD(1'b1)) u_dut_fold (
        .clk     (clk),
        .reset_n (reset_n),
        .kbd_if  (if_f1)
    );

    keyboard_cmd_fsm #(.CASE_FOLD(1'b0)) u_dut_nofold (
        .clk     (clk),
        .reset_n (reset_n),
        .kbd_if  (if_f0)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model, index 0 = folding instance, 1 = non-folding instance
    int m_speed [2];
    bit m_play  [2];
    bit m_fwd   [2];
    int m_rst   [2];

    typedef struct {
        logic [7:0] key;
        logic       valid;
        logic [3:0] st;
        int         spd;
    } vec_t;

    vec_t tbl [14];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_speed[i] = 1136;
            m_play[i]  = 1'b0;
            m_fwd[i]   = 1'b1;
            m_rst[i]   = 0;
        end
    endfunction

    function automatic void model_step(logic [7:0] key, logic valid);
        for (int i = 0; i < 2; i++) begin
            int k;
            bit r;
            k = int'(key);
            r = 1'b0;
            if (valid) begin
                if (i == 0 && k >= 97 && k <= 122) k = k - 32;
                case (k)
                    'h45: m_play[i] = 1'b1;
                    'h44: m_play[i] = 1'b0;
                    'h46: m_fwd[i]  = 1'b1;
                    'h42: m_fwd[i]  = 1'b0;
                    'h52: r = 1'b1;
                    'h55: m_speed[i] = (m_speed[i] - 64 < 256) ? 256 : m_speed[i] - 64;
                    'h4C: m_speed[i] = (m_speed[i] + 64 > 4544) ? 4544 : m_speed[i] + 64;
                    'h54: m_speed[i] = 1136;
                    default: ;
                endcase
            end
            m_rst[i] = r ? 4 : ((m_rst[i] > 0) ? m_rst[i] - 1 : 0);
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " f1.state"},   int'(if_f1.state),            (m_play[0] ? 2 : 0) + (m_fwd[0] ? 1 : 0));
        chk({tag, " f1.fwd"},     int'(if_f1.forward_backward), int'(m_fwd[0]));
        chk({tag, " f1.play"},    int'(if_f1.play_stop),        int'(m_play[0]));
        chk({tag, " f1.restart"}, int'(if_f1.restart),          (m_rst[0] > 0) ? 1 : 0);
        chk({tag, " f1.speed"},   int'(if_f1.speed_div),        m_speed[0]);
        chk({tag, " f0.state"},   int'(if_f0.state),            (m_play[1] ? 2 : 0) + (m_fwd[1] ? 1 : 0));
        chk({tag, " f0.fwd"},     int'(if_f0.forward_backward), int'(m_fwd[1]));
        chk({tag, " f0.play"},    int'(if_f0.play_stop),        int'(m_play[1]));
        chk({tag, " f0.restart"}, int'(if_f0.restart),          (m_rst[1] > 0) ? 1 : 0);
        chk({tag, " f0.speed"},   int'(if_f0.speed_div),        m_speed[1]);
    endtask

    task automatic drive(input logic [7:0] key, input logic valid);
        if_f1.key_data  = key;
        if_f1.key_valid = valid;
        if_f0.key_data  = key;
        if_f0.key_valid = valid;
    endtask

    task automatic cyc(input logic [7:0] key, input logic valid, input string tag);
        @(negedge clk);
        drive(key, valid);
        @(posedge clk);
        model_step(key, valid);
        #1;
        check_model(tag);
    endtask

    logic [7:0] pool [12];

    initial begin
        tbl[0]  = '{8'h45, 1'b1, ST_PLAY_FWD, 1136};
        tbl[1]  = '{8'h42, 1'b1, ST_PLAY_BWD, 1136};
        tbl[2]  = '{8'h46, 1'b1, ST_PLAY_FWD, 1136};
        tbl[3]  = '{8'h44, 1'b1, ST_STOP_FWD, 1136};
        tbl[4]  = '{8'h45, 1'b0, ST_STOP_FWD, 1136};
        tbl[5]  = '{8'h65, 1'b1, ST_PLAY_FWD, 1136};
        tbl[6]  = '{8'h5A, 1'b1, ST_PLAY_FWD, 1136};
        tbl[7]  = '{8'h64, 1'b1, ST_STOP_FWD, 1136};
        tbl[8]  = '{8'h55, 1'b1, ST_STOP_FWD, 1072};
        tbl[9]  = '{8'h75, 1'b1, ST_STOP_FWD, 1008};
        tbl[10] = '{8'h4C, 1'b1, ST_STOP_FWD, 1072};
        tbl[11] = '{8'h54, 1'b1, ST_STOP_FWD, 1136};
        tbl[12] = '{8'h62, 1'b1, ST_STOP_BWD, 1136};
        tbl[13] = '{8'h45, 1'b1, ST_PLAY_BWD, 1136};

        pool = '{8'h45, 8'h44, 8'h46, 8'h42, 8'h52, 8'h55,
                 8'h4C, 8'h54, 8'h65, 8'h75, 8'h6C, 8'h72};

        reset_n = 1'b1;
        drive(8'h00, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_model("reset");
        chk("reset.state", int'(if_f1.state), int'(ST_STOP_FWD));
        chk("reset.speed", int'(if_f1.speed_div), 1136);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].key, tbl[i].valid, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.state", i),   int'(if_f1.state),     int'(tbl[i].st));
            chk($sformatf("tbl%0d.speed", i),   int'(if_f1.speed_div), tbl[i].spd);
            chk($sformatf("tbl%0d.restart", i), int'(if_f1.restart),   0);
        end

        // key_data held without strobe must not act
        cyc(8'h44, 1'b1, "stop");
        for (int i = 0; i < 10; i++) cyc(8'h45, 1'b0, "hold");
        chk("hold.state", int'(if_f1.state), int'(ST_STOP_BWD));

        cyc(8'h52, 1'b1, "r1");
        chk("r1.restart", int'(if_f1.restart), 1);
        for (int i = 0; i < 4; i++) begin
            cyc(8'h00, 1'b0, "r1_idle");
            chk($sformatf("r1.pulse%0d", i), int'(if_f1.restart), (i < 3) ? 1 : 0);
        end

        cyc(8'h52, 1'b1, "r2a");
        cyc(8'h00, 1'b0, "r2_gap");
        cyc(8'h52, 1'b1, "r2b");
        chk("r2.restart", int'(if_f1.restart), 1);
        for (int i = 0; i < 4; i++) begin
            cyc(8'h00, 1'b0, "r2_idle");
            chk($sformatf("r2.pulse%0d", i), int'(if_f1.restart), (i < 3) ? 1 : 0);
        end
        chk("r2.state", int'(if_f1.state), int'(ST_STOP_BWD));

        for (int i = 0; i < 20; i++) begin
            cyc(8'h55, 1'b1, "up");
            if (i == 0) chk("up.first", int'(if_f1.speed_div), 1072);
            if (i == 1) chk("up.second", int'(if_f1.speed_div), 1008);
        end
        chk("up.sat", int'(if_f1.speed_div), 256);
        for (int i = 0; i < 100; i++) cyc(8'h4C, 1'b1, "down");
        chk("down.sat", int'(if_f1.speed_div), 4544);
        cyc(8'h54, 1'b1, "spd_rst");
        chk("spd_rst", int'(if_f1.speed_div), 1136);

        // asynchronous reset in the middle of a restart pulse
        cyc(8'h52, 1'b1, "ar_r");
        cyc(8'h4C, 1'b1, "ar_l");
        cyc(8'h45, 1'b1, "ar_e");
        @(negedge clk);
        drive(8'h00, 1'b0);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        chk("async_rst.restart", int'(if_f1.restart), 0);
        chk("async_rst.speed", int'(if_f1.speed_div), 1136);
        chk("async_rst.state", int'(if_f1.state), int'(ST_STOP_FWD));
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            logic [7:0] k;
            int sel;
            sel = int'($urandom_range(0, 15));
            k = (sel < 12) ? pool[sel] : 8'($urandom);
            cyc(k, ($urandom_range(0, 3) != 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
